// File: rtl/drp_master_mc.sv
// drp_master_mc: single-outstanding DRP access master for NUM_CH transceiver
// channels sharing one address/data bus, with per-channel enables, a
// ready timeout and a bad-channel error.
// Optional feature: define DRP_RMW_EN to enable read-modify-write accesses.
module drp_master_mc #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     DRPCLK_i,
    input  logic                     RESETN_i,
    input  logic                     req_i,
    input  logic [3:0]               ch_sel_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [DATA_W-1:0]        di_i,
    input  logic                     we_i,
    input  logic                     rmw_i,
    input  logic [DATA_W-1:0]        mask_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     timeout_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [ADDR_W-1:0]        drp_addr_o,
    output logic [DATA_W-1:0]        drp_di_o,
    output logic [NUM_CH-1:0]        drp_en_o,
    output logic [NUM_CH-1:0]        drp_we_o,
    input  logic [NUM_CH*DATA_W-1:0] drp_do_i,
    input  logic [NUM_CH-1:0]        drp_rdy_i
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT     = 3'd2,
`ifdef DRP_RMW_EN
        RMW_WR   = 3'd3,
        RMW_WAIT = 3'd4,
`endif
        DONE     = 3'd5
    } state_t;

    state_t              state, next_state;
    logic                req_prev, armed, req_rise, ch_ok;
    logic [3:0]          ch_q;
    logic                we_q, rmw_q;
    logic [15:0]         cnt;
    logic [NUM_CH-1:0]   sel;
    logic [DATA_W-1:0]   do_sel;
    logic                rdy_hit, tmo_hit;
    logic                accept, cap_rd, set_tmo, cnt_clr, cnt_inc;

`ifdef DRP_RMW_EN
    logic [DATA_W-1:0]   mask_q;
`else
    logic                unused_rmw;
    assign unused_rmw = ^{rmw_i, mask_i};
    assign rmw_q      = 1'b0;
`endif

    // A request needs req_i to have been seen low since reset, so a level held through reset is not an edge
    assign req_rise = req_i & ~req_prev & armed;
    assign ch_ok    = 32'(ch_sel_i) < NUM_CH;
    assign rdy_hit  = |(drp_rdy_i & sel);
    // Leaving on the cycle the counter would reach TIMEOUT_CYC-1 ends the access TIMEOUT_CYC cycles after enable
    assign tmo_hit  = (cnt == 16'(TIMEOUT_CYC - 2));
    assign busy_o   = (state != IDLE);
    assign done_o   = (state == DONE);

    // One-hot decode of the latched channel and the matching read-data slice
    always_comb begin
        sel    = '0;
        do_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel[k] = (ch_q == 4'(k));
            if (sel[k]) begin
                do_sel = do_sel | drp_do_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge DRPCLK_i or negedge RESETN_i) begin
        if (!RESETN_i) state <= IDLE;
        else           state <= next_state;
    end

    // Next-state decode plus DRP strobes and datapath controls
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        cap_rd     = 1'b0;
        set_tmo    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        drp_en_o   = '0;
        drp_we_o   = '0;
        case (state)
            IDLE: begin
                if (req_rise) begin
                    accept     = 1'b1;
                    next_state = ch_ok ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                drp_en_o   = sel;
                drp_we_o   = (we_q & ~rmw_q) ? sel : '0;
                cnt_clr    = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (rdy_hit) begin
                    cap_rd = ~we_q | rmw_q;
`ifdef DRP_RMW_EN
                    next_state = rmw_q ? RMW_WR : DONE;
`else
                    next_state = DONE;
`endif
                end else if (tmo_hit) begin
                    set_tmo    = 1'b1;
                    next_state = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`ifdef DRP_RMW_EN
            RMW_WR: begin
                drp_en_o   = sel;
                drp_we_o   = sel;
                cnt_clr    = 1'b1;
                next_state = RMW_WAIT;
            end
            RMW_WAIT: begin
                if (rdy_hit) begin
                    next_state = DONE;
                end else if (tmo_hit) begin
                    set_tmo    = 1'b1;
                    next_state = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latching, status flags, read capture and the ready timeout counter
    always_ff @(posedge DRPCLK_i or negedge RESETN_i) begin
        if (!RESETN_i) begin
            req_prev   <= 1'b0;
            armed      <= 1'b0;
            ch_q       <= '0;
            we_q       <= 1'b0;
            drp_addr_o <= '0;
            drp_di_o   <= '0;
            rdata_o    <= '0;
            err_o      <= 1'b0;
            timeout_o  <= 1'b0;
            cnt        <= '0;
`ifdef DRP_RMW_EN
            rmw_q      <= 1'b0;
            mask_q     <= '0;
`endif
        end else begin
            req_prev <= req_i;
            if (!req_i) armed <= 1'b1;
            if (accept) begin
                ch_q       <= ch_sel_i;
                we_q       <= we_i;
                drp_addr_o <= addr_i;
                drp_di_o   <= di_i;
                err_o      <= ~ch_ok;
                timeout_o  <= 1'b0;
`ifdef DRP_RMW_EN
                rmw_q      <= we_i & rmw_i;
                mask_q     <= mask_i;
`endif
            end
            if (cap_rd) begin
                rdata_o <= do_sel;
`ifdef DRP_RMW_EN
                if (rmw_q) drp_di_o <= (do_sel & ~mask_q) | (drp_di_o & mask_q);
`endif
            end
            if (set_tmo) timeout_o <= 1'b1;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: doc/drp_master_mc.md
DRP_MASTER_MC -- requirements
Module: drp_master_mc

Interface
REQ-001 Parameter NUM_CH, default 4, number of DRP-attached transceiver channels (1..16).
REQ-002 Parameter ADDR_W, default 9, DRP address width.
REQ-003 Parameter DATA_W, default 16, DRP data width.
REQ-004 Parameter TIMEOUT_CYC, default 64, cycles waited for drp_rdy before abort (2..65535).
REQ-005 Clock/reset: one clock, DRPCLK_i; reset RESETN_i is asynchronous, active-low; all ports below are synchronous to DRPCLK_i.
REQ-006 DRPCLK_i  in  1  free-running DRP clock.
REQ-007 RESETN_i  in  1  async active-low reset.
REQ-008 req_i  in  1  level trigger, already synchronised; rising edge requests one access.
REQ-009 ch_sel_i  in  4  target channel index.
REQ-010 addr_i / di_i / we_i  in  ADDR_W / DATA_W / 1  access address, write data, 1 = write.
REQ-011 rmw_i / mask_i  in  1 / DATA_W  read-modify-write select and bit mask (used only when DRP_RMW_EN is defined).
REQ-012 busy_o / done_o / err_o / timeout_o  out  1 each  access in progress / 1-cycle completion pulse / bad channel / no drp_rdy.
REQ-013 rdata_o  out  DATA_W  last read data.
REQ-014 drp_addr_o / drp_di_o  out  ADDR_W / DATA_W  shared DRP address and data bus to all channels.
REQ-015 drp_en_o / drp_we_o  out  NUM_CH each  per-channel enable and write-enable.
REQ-016 drp_do_i / drp_rdy_i  in  NUM_CH*DATA_W / NUM_CH  per-channel read data (channel k at bits k*DATA_W +: DATA_W) and ready.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, (RMW_WR, RMW_WAIT when DRP_RMW_EN), DONE.
REQ-018 A request is a rising edge of req_i (registered previous value), accepted only in IDLE; edges while not IDLE are discarded, not queued.
REQ-019 On acceptance ch_sel_i, addr_i, di_i, we_i, rmw_i, mask_i are latched; later input changes do not affect the access; err_o and timeout_o clear.
REQ-020 If latched ch_sel >= NUM_CH: no drp_en asserted, FSM goes IDLE->DONE, err_o = 1.
REQ-021 ISSUE: drp_en_o[ch] high exactly one cycle, drp_we_o[ch] = latched we (0 for the read phase of RMW); other channels' en/we stay 0; drp_en_o rises on the cycle after the edge is sampled.
REQ-022 drp_addr_o/drp_di_o are driven from latched values for the whole access and hold their last value otherwise.
REQ-023 WAIT: timeout counter starts at 0 on the cycle after en; drp_rdy_i[ch] high -> capture drp_do_i[ch] into rdata_o for reads, go DONE.
REQ-024 drp_rdy_i from unselected channels, or while in IDLE/ISSUE/DONE, is ignored.
REQ-025 Counter reaching TIMEOUT_CYC-1 without rdy -> timeout_o = 1, go DONE; rdata_o unchanged; rdy on that same cycle counts as success (rdy wins).
REQ-026 DONE: done_o high one cycle, then IDLE; busy_o = 1 in every state except IDLE.
REQ-027 Minimum access latency, edge sample to done_o: 3 cycles when rdy returns the cycle after en.
REQ-028 err_o, timeout_o, rdata_o hold until the next accepted request.

Reset
REQ-029 RESETN_i low asynchronously forces IDLE; busy_o, done_o, err_o, timeout_o, drp_en_o, drp_we_o = 0; rdata_o, drp_addr_o, drp_di_o = 0; counter and edge register = 0.
REQ-030 Reset mid-access abandons it with no done_o; after release a req_i already high is not a rising edge until it falls and rises again.

Configuration
REQ-031 Macro DRP_RMW_EN: when defined, an accepted request with we=1 and rmw=1 performs read (ISSUE/WAIT), then RMW_WR writes (old & ~mask) | (di & mask) with drp_we=1, RMW_WAIT waits with its own timeout; rdata_o = old value; a timeout in either phase ends the access with timeout_o = 1 and no further DRP cycles.
REQ-032 When DRP_RMW_EN is undefined: rmw_i and mask_i are unused, RMW states are absent, every write is a plain write.

Verification
REQ-033 Read ch2 addr 0x05A, rdy 1 cycle after en, do=0xBEEF -> drp_en_o=0b0100 for one cycle, we=0, rdata_o=0xBEEF, done_o pulse 3 cycles after edge.
REQ-034 Write ch0 addr 0x1FF di=0x1234, rdy never returns, TIMEOUT_CYC=64 -> timeout_o=1 and done_o 64 cycles after en, rdata_o unchanged.
REQ-035 ch_sel=NUM_CH -> no drp_en on any channel, err_o=1, done_o pulse.
REQ-036 Second req_i edge during WAIT plus rdy on ch1 while ch3 selected -> edge discarded, ch1 rdy ignored, exactly one done_o.
REQ-037 DRP_RMW_EN: old=0xF0F0, di=0x0A0A, mask=0x00FF -> read then write of 0xF00A to same addr, rdata_o=0xF0F0.
REQ-038 RESETN_i low during WAIT with req_i held high -> all outputs 0 immediately; no access after release until req_i toggles.
